// File: rtl/factorial_pkg.sv
// Shared definitions for the factorial datapath: mux select codes,
// controller state encoding and the largest operand the 32-bit
// accumulator can hold the factorial of.
package factorial_pkg;

    // 12! = 479001600 is the largest factorial that fits in 32 bits
    localparam int MAX_N = 12;

    // Accumulator mux select codes, shared with the mux itself
    localparam logic [1:0] SEL_ONE  = 2'b00;
    localparam logic [1:0] SEL_PROD = 2'b01;
    localparam logic [1:0] SEL_HOLD = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_MULT,
        ST_DONE,
        ST_ERR
    } state_t;

    // Bundle of the controller's Moore outputs, kept together so the
    // FSM can register them in one assignment alongside the state
    typedef struct packed {
        logic       ready;
        logic       busy;
        logic       done;
        logic       error;
        logic [1:0] muxSel;
        logic       accEn;
    } ctrl_out_t;

    // Output decode for a given state; SEL_HOLD with the load disabled
    // is the safe default so the accumulator never changes by accident
    function automatic ctrl_out_t decodeState(input state_t s);
        ctrl_out_t o;
        o.ready  = 1'b0;
        o.busy   = 1'b0;
        o.done   = 1'b0;
        o.error  = 1'b0;
        o.muxSel = SEL_HOLD;
        o.accEn  = 1'b0;
        case (s)
            ST_IDLE: o.ready = 1'b1;
            ST_INIT: begin
                o.busy   = 1'b1;
                o.muxSel = SEL_ONE;
                o.accEn  = 1'b1;
            end
            ST_MULT: begin
                o.busy   = 1'b1;
                o.muxSel = SEL_PROD;
                o.accEn  = 1'b1;
            end
            ST_DONE: o.done  = 1'b1;
            ST_ERR:  o.error = 1'b1;
            default: o.ready = 1'b0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/factorial_ctrl_down_counter.sv
// Loadable down-counter holding the multiplier operand k. A load wins
// over a decrement, and the count floors at zero instead of wrapping.
module down_counter #(
    parameter int N_W = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load,
    input  logic [N_W-1:0] load_val,
    input  logic           dec,
    output logic [N_W-1:0] count
);

    logic [N_W-1:0] r_count;

    // Load the operand on an accepted request, otherwise count down while asked
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (dec && (r_count != '0)) begin
            r_count <= r_count - N_W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/factorial_ctrl.sv
// Sequencing controller for the factorial datapath. Drives the
// accumulator mux select and load enable, and owns the down-counter
// that supplies the multiplier operand k. All outputs are registered
// decodes of the state, so start/n never reach an output directly.
module factorial_ctrl
    import factorial_pkg::*;
#(
    parameter int N_W   = 4,
    parameter int MAX_N = factorial_pkg::MAX_N
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [N_W-1:0] n,
    output logic           ready,
    output logic           busy,
    output logic           done,
    output logic           error,
    output logic [1:0]     mux_sel,
    output logic           acc_en,
    output logic [N_W-1:0] k
);

    localparam logic [N_W-1:0] N_LIMIT = N_W'(MAX_N);
    localparam logic [N_W-1:0] K_ONE   = N_W'(1);
    localparam logic [N_W-1:0] K_TWO   = N_W'(2);

    state_t         r_state;
    ctrl_out_t      r_ctrl;
    logic           w_nLegal;
    logic           w_load;
    logic           w_dec;
    logic [N_W-1:0] w_count;

    assign w_nLegal = (n <= N_LIMIT);

    // The counter only takes the operand when IDLE actually accepts a
    // legal request, so an out-of-range n leaves k untouched
    assign w_load = (r_state == ST_IDLE) && start && w_nLegal;
    assign w_dec  = (r_state == ST_MULT);

    down_counter #(
        .N_W(N_W)
    ) u_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (w_load),
        .load_val (n),
        .dec      (w_dec),
        .count    (w_count)
    );

    // Sequencer: each transition registers the next state together
    // with that state's outputs, keeping every output glitch-free
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_ctrl  <= decodeState(ST_IDLE);
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start && w_nLegal) begin
                        r_state <= ST_INIT;
                        r_ctrl  <= decodeState(ST_INIT);
                    end else if (start) begin
                        r_state <= ST_ERR;
                        r_ctrl  <= decodeState(ST_ERR);
                    end
                end
                ST_INIT: begin
                    if (w_count <= K_ONE) begin
                        r_state <= ST_DONE;
                        r_ctrl  <= decodeState(ST_DONE);
                    end else begin
                        r_state <= ST_MULT;
                        r_ctrl  <= decodeState(ST_MULT);
                    end
                end
                ST_MULT: begin
                    if (w_count <= K_TWO) begin
                        r_state <= ST_DONE;
                        r_ctrl  <= decodeState(ST_DONE);
                    end
                end
                ST_DONE, ST_ERR: begin
                    r_state <= ST_IDLE;
                    r_ctrl  <= decodeState(ST_IDLE);
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ctrl  <= decodeState(ST_IDLE);
                end
            endcase
        end
    end

    assign ready   = r_ctrl.ready;
    assign busy    = r_ctrl.busy;
    assign done    = r_ctrl.done;
    assign error   = r_ctrl.error;
    assign mux_sel = r_ctrl.muxSel;
    assign acc_en  = r_ctrl.accEn;
    assign k       = w_count;

endmodule

// File: tb/tb_factorial_ctrl.sv
// Testbench for factorial_ctrl: a reference mux/multiplier/accumulator
// is driven by the controller, and every run is judged against the
// factorial, latency and select sequence computed from n alone.
module tb_factorial_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  n;
    logic        ready;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  mux_sel;
    logic        acc_en;
    logic [3:0]  k;
    logic [31:0] acc;

    int testCount = 0;
    int failCount = 0;

    factorial_ctrl #(
        .N_W   (4),
        .MAX_N (12)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .n       (n),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .error   (error),
        .mux_sel (mux_sel),
        .acc_en  (acc_en),
        .k       (k)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference datapath: three-input mux feeding the accumulator
    always @(posedge clk) begin
        if (acc_en) begin
            case (mux_sel)
                2'b00:   acc <= 32'd1;
                2'b01:   acc <= acc * 32'(k);
                default: acc <= acc;
            endcase
        end
    end

    // Hard stop in case the bench itself loses its way
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] factorial(input int v);
        logic [31:0] p;
        p = 32'd1;
        for (int i = 2; i <= v; i++) p = p * 32'(i);
        return p;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // Present a request for one rising edge, returning at the negedge
    // of the first cycle after acceptance
    task automatic applyStimulus(input int nv);
        start = 1'b1;
        n     = 4'(nv);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Follow an accepted legal run from its first cycle to its done
    // cycle; optionally pulse start again at cycle pulseAt
    task automatic checkRun(input int nv, input int pulseAt);
        int lat;
        lat = 2 + ((nv > 1) ? nv - 1 : 0);
        for (int c = 1; c <= lat; c++) begin
            if (c == 1) begin
                checkOutput("init_sel", 32'(mux_sel), 32'd0);
                checkOutput("init_en", 32'(acc_en), 32'd1);
                checkOutput("init_busy", 32'(busy), 32'd1);
                checkOutput("init_ready", 32'(ready), 32'd0);
                checkOutput("init_done", 32'(done), 32'd0);
            end else if (c < lat) begin
                checkOutput("mult_sel", 32'(mux_sel), 32'd1);
                checkOutput("mult_en", 32'(acc_en), 32'd1);
                checkOutput("mult_k", 32'(k), 32'(nv - (c - 2)));
                checkOutput("mult_done", 32'(done), 32'd0);
            end else begin
                checkOutput("done_pulse", 32'(done), 32'd1);
                checkOutput("done_acc", acc, factorial(nv));
                checkOutput("done_sel", 32'(mux_sel), 32'd2);
                checkOutput("done_en", 32'(acc_en), 32'd0);
                checkOutput("done_busy", 32'(busy), 32'd0);
            end
            if (c < lat) begin
                if (c == pulseAt) begin
                    start = 1'b1;
                    n     = 4'($urandom_range(0, 15));
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
                start = 1'b0;
            end
        end
    endtask

    task automatic runOp(input int nv, input int pulseAt);
        checkOutput("ready_before", 32'(ready), 32'd1);
        applyStimulus(nv);
        checkRun(nv, pulseAt);
        @(negedge clk);
        checkOutput("ready_after", 32'(ready), 32'd1);
        checkOutput("done_single", 32'(done), 32'd0);
    endtask

    // Out-of-range request: one error cycle, accumulator and k untouched
    task automatic errRun(input int nv);
        logic [31:0] accBefore;
        logic [3:0]  kBefore;
        accBefore = acc;
        kBefore   = k;
        applyStimulus(nv);
        checkOutput("err_pulse", 32'(error), 32'd1);
        checkOutput("err_en", 32'(acc_en), 32'd0);
        checkOutput("err_sel", 32'(mux_sel), 32'd2);
        checkOutput("err_ready", 32'(ready), 32'd0);
        checkOutput("err_busy", 32'(busy), 32'd0);
        @(negedge clk);
        checkOutput("err_clear", 32'(error), 32'd0);
        checkOutput("err_ready_back", 32'(ready), 32'd1);
        checkOutput("err_acc_kept", acc, accBefore);
        checkOutput("err_k_kept", 32'(k), 32'(kBefore));
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_ready"}, 32'(ready), 32'd1);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_sel"}, 32'(mux_sel), 32'd2);
        checkOutput({tag, "_en"}, 32'(acc_en), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_error"}, 32'(error), 32'd0);
    endtask

    initial begin
        int nv;
        int gap;
        reset = 1'b1;
        start = 1'b0;
        n     = 4'd0;
        #2;
        checkIdle("in_reset");
        checkOutput("in_reset_k", 32'(k), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Quiet idle period after reset
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkIdle("idle");
        end

        // Directed runs: typical, trivial operands and the largest legal n
        runOp(5, 0);
        runOp(0, 0);
        runOp(1, 0);
        runOp(2, 0);
        runOp(12, 0);
        errRun(13);
        errRun(15);

        // A second start during MULT must be ignored
        runOp(7, 4);

        // start held through DONE is ignored there, then taken in IDLE
        checkOutput("ready_before", 32'(ready), 32'd1);
        applyStimulus(4);
        checkRun(4, 0);
        start = 1'b1;
        n     = 4'd3;
        @(negedge clk);
        checkOutput("held_ready", 32'(ready), 32'd1);
        checkOutput("held_busy", 32'(busy), 32'd0);
        @(negedge clk);
        start = 1'b0;
        checkRun(3, 0);
        @(negedge clk);

        // Reset in the third MULT cycle of n=9 aborts without done
        applyStimulus(9);
        for (int c = 1; c < 4; c++) @(negedge clk);
        checkOutput("abort_sel", 32'(mux_sel), 32'd1);
        checkOutput("abort_k", 32'(k), 32'd7);
        #2 reset = 1'b1;
        #1;
        checkIdle("abort_async");
        checkOutput("abort_k_reset", 32'(k), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkIdle("after_abort");
        end
        runOp(3, 0);

        // Randomized mix of legal and illegal operands with idle gaps
        for (int i = 0; i < 12; i++) begin
            nv  = int'($urandom_range(0, 15));
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) @(negedge clk);
            if (nv > 12) errRun(nv);
            else runOp(nv, int'($urandom_range(0, 6)));
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/factorial_ctrl.md
# factorial_ctrl

Sequencing controller for the factorial datapath. It drives the 2-bit select of the three-input accumulator mux (00 = constant 1, 01 = product, 10 = hold/feedback) and the accumulator load enable. It owns the down-counter `k` that feeds the multiplier operand. It sits directly upstream of the mux select input and accepts a start/n request from the host.

## Interface
Parameters:
- `N_W`, 4: width of the operand `n` and the counter `k`.
- `MAX_N`, 12: largest legal `n`; 12! = 479001600 is the largest factorial that fits the 32-bit accumulator.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high; forces the reset state immediately.
- `start` in 1: request pulse; sampled only in IDLE.
- `n` in N_W: operand; sampled with `start`.
- `ready` out 1: high in IDLE only.
- `busy` out 1: high in INIT and MULT.
- `done` out 1: one-cycle pulse; the accumulator holds n! in this cycle.
- `error` out 1: one-cycle pulse when `n` > MAX_N.
- `mux_sel` out 2: the mux select (C).
- `acc_en` out 1: accumulator register load enable.
- `k` out N_W: current multiplier operand (multiplier computes acc × k into mux I2).

## Operation
- States: IDLE, INIT, MULT, DONE, ERR. Encoding is internal.
- IDLE
  - Outputs: `ready`=1, `mux_sel`=10, `acc_en`=0.
  - `start`=1 and `n` ≤ MAX_N: load `k`←`n`, go to INIT.
  - `start`=1 and `n` > MAX_N: go to ERR, `k` unchanged.
  - Otherwise stay in IDLE.
- INIT
  - Outputs: `mux_sel`=00, `acc_en`=1 (acc←1), `busy`=1.
  - `k` ≤ 1: go to DONE. Otherwise go to MULT.
- MULT
  - Outputs: `mux_sel`=01, `acc_en`=1 (acc←acc×k), `busy`=1.
  - Each cycle `k`←`k`−1.
  - `k`==2 in this cycle: go to DONE. Otherwise stay in MULT.
  - `k` never decrements below 1, so there is no wrap-around.
- DONE
  - Outputs: `done`=1, `mux_sel`=10, `acc_en`=0.
  - Go to IDLE unconditionally.
- ERR
  - Outputs: `error`=1, `mux_sel`=10, `acc_en`=0.
  - Go to IDLE unconditionally.
- `mux_sel` value 11 is never driven.
- All outputs are decoded from the registered state and `k` (Moore). There is no combinational path from `start`/`n` to any output.
- `start` outside IDLE is ignored. This includes `start` in the DONE/ERR cycles; no queuing.
- Held `start` in IDLE after DONE begins a new run (level-sampled).

## Timing
- Reset values: state=IDLE, `k`=0, `ready`=1, `busy`=0, `done`=0, `error`=0, `mux_sel`=10, `acc_en`=0.
- Start accepted at edge E0. Then:
  - INIT occupies the cycle after E0.
  - MULT occupies max(n−1,0) cycles.
  - DONE follows.
- Start-to-`done` latency = 2 + max(n−1,0) cycles. Examples: n=0 or 1 → 2 cycles; n=5 → 6 cycles; n=12 → 13 cycles.
- Error latency: `error` is high in the cycle after the accepting edge; `ready` returns the cycle after that.
- `ready` to next accepted start: minimum 0 cycles (start may be asserted in the same cycle `ready` rises).
- Reset mid-run (any state): immediate return to the reset values.
  - `done`/`error` are not emitted.
  - The accumulator content is don't-care until the next INIT.

## Structure
- Shared package `factorial_pkg`:
  - Mux select constants: `SEL_ONE`=00, `SEL_PROD`=01, `SEL_HOLD`=10. The mux and this block both use these.
  - The state enum.
  - `MAX_N`.
- Sub-module `down_counter`: N_W-bit loadable decrementer with ports `load`, `load_val`, `dec`, `count`. The FSM drives `load` in IDLE on accepted start and `dec` in MULT.
- The FSM and output decode live in `factorial_ctrl`.

## Test plan
- Reset, then idle for 5 cycles → `ready`=1, `mux_sel`=10, `acc_en`=0, `done`=`error`=0 throughout.
- start with n=5, with a reference mux/accumulator/multiplier → `mux_sel` sequence 00,01,01,01,01,10. `k` values during MULT are 5,4,3,2. `done` rises 6 cycles after start with acc=120.
- n=0 and n=1 (separate runs) → INIT then DONE, no MULT cycles, acc=1, latency 2.
- n=12 → 11 MULT cycles, `done` with acc=479001600. Then n=13 → `error` pulse one cycle after start, `acc_en` never asserted, accumulator unchanged.
- start pulsed again during MULT of an n=7 run → ignored; single `done` with acc=5040 at latency 8.
- reset asserted during the third MULT cycle of n=9 → outputs return to reset values asynchronously, no `done`. A following n=3 run gives acc=6.
